// File: rtl/hcordic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hcordic_pkg : packet layout, NOP tag and slot-entry type             |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package hcordic_pkg;

  localparam int PKT_W       = 108;  // {tag, opcode, z, y, x}
  localparam int RES_W       = 104;  // {tag, z, y, x}
  localparam int TAG_W       = 8;
  localparam int OPC_W       = 4;
  localparam int DATA_W      = 96;   // z, y, x at [95:64], [63:32], [31:0]
  localparam int TAG_LSB     = 100;
  localparam int OPC_LSB     = 96;
  localparam int RES_TAG_LSB = 96;
  localparam int SLOT_MAX    = 16;
  localparam int SLOT_IDX_W  = 4;

  localparam logic [TAG_W-1:0] NOP_TAG = 8'hFF;

  typedef struct packed {
    logic             req_id;
    logic [TAG_W-1:0] tag;
  } slot_entry_t;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} issue_state_t;

  function automatic logic [PKT_W-1:0] nop_packet(input logic [OPC_W-1:0] opcode);
    return {NOP_TAG, opcode, {DATA_W{1'b0}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/hcordic_slot_alloc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hcordic_slot_alloc : lowest-free slot search, free and occupancy     |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
module hcordic_slot_alloc
  import hcordic_pkg::*;
#(
  parameter int NUM_SLOTS = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alloc_en,
  input  logic                  free_en,
  input  logic [SLOT_IDX_W-1:0] free_idx,
  output logic [SLOT_IDX_W-1:0] alloc_idx,
  output logic                  full,
  output logic [SLOT_MAX-1:0]   used,
  output logic [4:0]            count
);

  logic [SLOT_MAX-1:0] used_nx;

  // Search is over the pre-free bitmap; a slot freed this edge is reusable next cycle.
  always_comb begin
    alloc_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!used[i]) alloc_idx = SLOT_IDX_W'(i);
    end
  end

  always_comb begin
    used_nx = used;
    if (free_en)  used_nx[free_idx]  = 1'b0;
    if (alloc_en) used_nx[alloc_idx] = 1'b1;
  end

  assign full = (count == 5'(NUM_SLOTS));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      used  <= '0;
      count <= '0;
    end else begin
      used  <= used_nx;
      count <= count + {4'b0, alloc_en} - {4'b0, free_en};
    end
  end

endmodule
`default_nettype wire

// File: rtl/hcordic_issue_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hcordic_issue_arbiter : two-requester round-robin issue to HCORDIC   |
// | Revision              : 1.0                                          |
// +----------------------------------------------------------------------+
module hcordic_issue_arbiter
  import hcordic_pkg::*;
#(
  parameter int         NUM_SLOTS  = 16,
  parameter logic [3:0] NOP_OPCODE = 4'hF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [PKT_W-1:0] req0_packet,
  input  logic [PKT_W-1:0] req1_packet,
  output logic [PKT_W-1:0] issue_packet,
  output logic             issue_valid,
  input  logic             pipe_ack,
  input  logic [RES_W-1:0] pipe_out_packet,
  input  logic             pipe_out_ready,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [RES_W-1:0] rsp0_packet,
  output logic [RES_W-1:0] rsp1_packet,
  output logic [4:0]       outstanding,
  output logic             stray_result
);

  issue_state_t          state, state_nx;
  logic                  last_grant;  // 1 when req1 won the previous grant
  logic                  gnt0, gnt1, grant, can_take, full, hit;
  logic [SLOT_IDX_W-1:0] alloc_idx, res_idx;
  logic [SLOT_MAX-1:0]   used;
  logic [PKT_W-1:0]      sel_pkt;
  slot_entry_t           slot_tab [SLOT_MAX];
  slot_entry_t           hit_entry;

  // Ready is gated by reset so the handshake drops the moment reset asserts.
  assign can_take = reset && !full && ((state == IDLE) || pipe_ack);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (can_take) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_grant;
        gnt1 = !last_grant;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign grant       = gnt0 || gnt1;
  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign sel_pkt     = gnt1 ? req1_packet : req0_packet;
  assign issue_valid = (state == BUSY);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant) state_nx = BUSY;
      BUSY:    if (!grant && pipe_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      issue_packet <= nop_packet(NOP_OPCODE);
    end else begin
      state <= state_nx;
      if (grant) begin
        last_grant   <= gnt1;
        issue_packet <= {4'b0, alloc_idx, sel_pkt[TAG_LSB-1:0]};
      end else if (state == BUSY && pipe_ack) begin
        issue_packet <= nop_packet(NOP_OPCODE);
      end
    end
  end

  assign res_idx   = pipe_out_packet[RES_TAG_LSB +: SLOT_IDX_W];
  assign hit_entry = slot_tab[res_idx];
  assign hit       = pipe_out_ready
                  && (pipe_out_packet[RES_TAG_LSB+SLOT_IDX_W +: 4] == 4'b0)
                  && used[res_idx];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SLOT_MAX; i++) slot_tab[i] <= '0;
    end else if (grant) begin
      slot_tab[alloc_idx] <= '{req_id: gnt1, tag: sel_pkt[TAG_LSB +: TAG_W]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp0_packet  <= '0;
      rsp1_packet  <= '0;
      stray_result <= 1'b0;
    end else begin
      rsp0_valid <= hit && !hit_entry.req_id;
      rsp1_valid <= hit &&  hit_entry.req_id;
      if (hit && !hit_entry.req_id)
        rsp0_packet <= {hit_entry.tag, pipe_out_packet[DATA_W-1:0]};
      if (hit && hit_entry.req_id)
        rsp1_packet <= {hit_entry.tag, pipe_out_packet[DATA_W-1:0]};
      if (pipe_out_ready && !hit) stray_result <= 1'b1;
    end
  end

  hcordic_slot_alloc #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_slot_alloc (
    .clock     (clock),
    .reset     (reset),
    .alloc_en  (grant),
    .free_en   (hit),
    .free_idx  (res_idx),
    .alloc_idx (alloc_idx),
    .full      (full),
    .used      (used),
    .count     (outstanding)
  );

endmodule
`default_nettype wire
